// File: rtl/hex_disp_pkg.sv
// Shared definitions for the hex display scan path: scan states, digit slot
// indices and the hex-to-7-segment lookup table (active-high, bit0=a .. bit6=g).
package hex_disp_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    // Digit slot order on the enable bus: current pair first, previous pair after.
    localparam logic [1:0] DIG_B1 = 2'd0;
    localparam logic [1:0] DIG_B2 = 2'd1;
    localparam logic [1:0] DIG_A1 = 2'd2;
    localparam logic [1:0] DIG_A2 = 2'd3;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [3:0] digit_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble to 7-segment decoder; one instance is shared by all
// four digits of the scanned display.
module hex_to_7seg
    import hex_disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/hex_display_scan_ctrl.sv
// Four-digit hex display scanner: keeps the current and previous nibble pairs,
// accepts new pairs through a req/ack handshake and multiplexes one decoder.
module hex_display_scan_ctrl
    import hex_disp_pkg::*;
#(
    parameter int PRESCALE     = 4,
    parameter int BLANK_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_req,
    input  logic [3:0] num1,
    input  logic [3:0] num2,
    output logic       load_ack,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    scan_state_e      state_q, state_d;
    logic [1:0]       digit_q, digit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             load_ack_q, load_ack_d;
    logic [3:0]       b1_q, b1_d;
    logic [3:0]       b2_q, b2_d;
    logic [3:0]       a1_q, a1_d;
    logic [3:0]       a2_q, a2_d;

    logic             load_fire;
    logic [3:0]       digit_val;
    logic [6:0]       dec_seg;

    // Loads land only at the very start of a slot, so a SHOW phase never sees
    // its digit value change; armed blocks a held request from reloading.
    assign load_fire = (state_q == BLANK) && (cnt_q == '0) && load_req && armed_q;

    always_comb begin
        state_d    = state_q;
        digit_d    = digit_q;
        cnt_d      = cnt_q + CNT_W'(1);
        armed_d    = armed_q;
        load_ack_d = load_fire;
        b1_d       = b1_q;
        b2_d       = b2_q;
        a1_d       = a1_q;
        a2_d       = a2_q;

        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end
            end
            SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    digit_d = digit_q + 2'd1;
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
        endcase

        if (load_fire) begin
            a1_d    = b1_q;
            a2_d    = b2_q;
            b1_d    = num1;
            b2_d    = num2;
            armed_d = 1'b0;
        end else if (!load_req) begin
            armed_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BLANK;
            digit_q    <= DIG_B1;
            cnt_q      <= '0;
            armed_q    <= 1'b1;
            load_ack_q <= 1'b0;
            b1_q       <= 4'h0;
            b2_q       <= 4'h0;
            a1_q       <= 4'h0;
            a2_q       <= 4'h0;
        end else begin
            state_q    <= state_d;
            digit_q    <= digit_d;
            cnt_q      <= cnt_d;
            armed_q    <= armed_d;
            load_ack_q <= load_ack_d;
            b1_q       <= b1_d;
            b2_q       <= b2_d;
            a1_q       <= a1_d;
            a2_q       <= a2_d;
        end
    end

    always_comb begin
        digit_val = b1_q;
        case (digit_q)
            DIG_B1:  digit_val = b1_q;
            DIG_B2:  digit_val = b2_q;
            DIG_A1:  digit_val = a1_q;
            DIG_A2:  digit_val = a2_q;
            default: digit_val = b1_q;
        endcase
    end

    hex_to_7seg u_dec (
        .nibble_i (digit_val),
        .seg_o    (dec_seg)
    );

    assign an       = (state_q == SHOW) ? digit_onehot(digit_q) : 4'b0000;
    assign seg      = (state_q == SHOW) ? dec_seg : 7'h00;
    assign load_ack = load_ack_q;

endmodule

// File: tb/tb_hex_display_scan_ctrl.sv
// Bench for the hex display scanner: a cycle-indexed reference of the scan
// timeline predicts {load_ack, an, seg} for every cycle into a scoreboard queue.
module tb_hex_display_scan_ctrl;

    localparam int PS   = 4;
    localparam int BL   = 1;
    localparam int SLOT = PS + BL;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_req;
    logic [3:0] num1;
    logic [3:0] num2;
    logic       load_ack;
    logic [3:0] an;
    logic [6:0] seg;

    always #5 clk = ~clk;

    hex_display_scan_ctrl #(
        .PRESCALE     (PS),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load_req (load_req),
        .num1     (num1),
        .num2     (num2),
        .load_ack (load_ack),
        .an       (an),
        .seg      (seg)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [11:0] exp_q[$];

    // Reference state: t is the index of the cycle currently on the outputs,
    // counted from the last reset edge.
    int         t;
    logic [3:0] md[4];
    logic       m_armed;
    logic       m_ack;
    int         ack_count;
    int         first_ack_cyc;

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    function automatic logic [11:0] ref_out();
        int         phase;
        int         slot;
        logic [3:0] a_exp;
        phase = t % SLOT;
        slot  = (t / SLOT) % 4;
        if (phase < BL) return {m_ack, 4'b0000, 7'h00};
        a_exp = 4'b0001 << slot;
        return {m_ack, a_exp, ref_seg(md[slot])};
    endfunction

    task automatic model_reset();
        t       = 0;
        m_armed = 1'b1;
        m_ack   = 1'b0;
        for (int i = 0; i < 4; i++) md[i] = 4'h0;
    endtask

    // Drive inputs for the current cycle and push the expected output of the next one.
    task automatic drive_cycle(input logic r, input logic req, input logic [3:0] n1, input logic [3:0] n2);
        rst      = r;
        load_req = req;
        num1     = n1;
        num2     = n2;
        if (r) begin
            model_reset();
        end else begin
            m_ack = 1'b0;
            if ((t % SLOT) == 0 && req && m_armed) begin
                md[2]   = md[0];
                md[3]   = md[1];
                md[0]   = n1;
                md[1]   = n2;
                m_armed = 1'b0;
                m_ack   = 1'b1;
            end else if (!req) begin
                m_armed = 1'b1;
            end
            t++;
        end
        exp_q.push_back(ref_out());
    endtask

    task automatic step_observe(output logic [11:0] got, output logic [11:0] exp);
        @(posedge clk);
        #1;
        got = {load_ack, an, seg};
        exp = exp_q.pop_front();
        if (load_ack === 1'b1) begin
            ack_count++;
            if (first_ack_cyc < 0) first_ack_cyc = t;
        end
    endtask

    task automatic apply_reset();
        logic [11:0] g;
        logic [11:0] e;
        drive_cycle(1'b1, 1'b0, 4'h0, 4'h0);
        step_observe(g, e);
        drive_cycle(1'b1, 1'b0, 4'h0, 4'h0);
        step_observe(g, e);
        ack_count     = 0;
        first_ack_cyc = -1;
    endtask

    task automatic test_reset();
        logic [11:0] got;
        logic [11:0] exp;
        ack_count     = 0;
        first_ack_cyc = -1;
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b1, 1'b1, 4'hF, 4'hF);
            step_observe(got, exp);
            tests_run++;
            if (got !== 12'h000) begin
                tests_failed++;
                $display("FAIL reset_outputs got ack=%b an=%b seg=%h need ack=0 an=0000 seg=00", got[11], got[10:7], got[6:0]);
            end
        end
        for (int c = 0; c < 10; c++) begin
            drive_cycle(1'b0, 1'b0, 4'h0, 4'h0);
            step_observe(got, exp);
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL reset_scan cyc=%0d got ack=%b an=%b seg=%h exp ack=%b an=%b seg=%h",
                         t, got[11], got[10:7], got[6:0], exp[11], exp[10:7], exp[6:0]);
            end
            if (t == 1) begin
                tests_run++;
                if (an !== 4'b0001 || seg !== 7'h3F) begin
                    tests_failed++;
                    $display("FAIL reset_first_digit got an=%b seg=%h need an=0001 seg=3f", an, seg);
                end
            end
        end
    endtask

    task automatic test_first_load();
        logic [11:0] got;
        logic [11:0] exp;
        apply_reset();
        for (int c = 0; c < 20; c++) begin
            drive_cycle(1'b0, (c <= 1), 4'h3, 4'hA);
            step_observe(got, exp);
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL first_load cyc=%0d got ack=%b an=%b seg=%h exp ack=%b an=%b seg=%h",
                         t, got[11], got[10:7], got[6:0], exp[11], exp[10:7], exp[6:0]);
            end
        end
        tests_run++;
        if (first_ack_cyc != 1 || ack_count != 1) begin
            tests_failed++;
            $display("FAIL first_load_ack got cyc=%0d count=%0d need cyc=1 count=1", first_ack_cyc, ack_count);
        end
    endtask

    task automatic test_second_load();
        logic [11:0] got;
        logic [11:0] exp;
        ack_count     = 0;
        first_ack_cyc = -1;
        for (int c = 0; c < 21; c++) begin
            drive_cycle(1'b0, (c <= 1), 4'h5, 4'hB);
            step_observe(got, exp);
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL second_load cyc=%0d got ack=%b an=%b seg=%h exp ack=%b an=%b seg=%h",
                         t, got[11], got[10:7], got[6:0], exp[11], exp[10:7], exp[6:0]);
            end
        end
        tests_run++;
        if (first_ack_cyc != 21 || ack_count != 1) begin
            tests_failed++;
            $display("FAIL second_load_ack got cyc=%0d count=%0d need cyc=21 count=1", first_ack_cyc, ack_count);
        end
    endtask

    task automatic test_held_req();
        logic [11:0] got;
        logic [11:0] exp;
        logic [3:0]  n1a, n2a, n1b, n2b;
        n1a = 4'($urandom_range(0, 15));
        n2a = 4'($urandom_range(0, 15));
        n1b = 4'($urandom_range(0, 15));
        n2b = 4'($urandom_range(0, 15));
        apply_reset();
        for (int c = 0; c < 51; c++) begin
            if (c == 41) begin
                tests_run++;
                if (ack_count != 1 || first_ack_cyc != 1) begin
                    tests_failed++;
                    $display("FAIL held_req_single_ack got count=%0d cyc=%0d need count=1 cyc=1", ack_count, first_ack_cyc);
                end
                ack_count     = 0;
                first_ack_cyc = -1;
            end
            if (c <= 40)      drive_cycle(1'b0, 1'b1, n1a, n2a);
            else if (c == 41) drive_cycle(1'b0, 1'b0, n1b, n2b);
            else              drive_cycle(1'b0, 1'b1, n1b, n2b);
            step_observe(got, exp);
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL held_req cyc=%0d got ack=%b an=%b seg=%h exp ack=%b an=%b seg=%h",
                         t, got[11], got[10:7], got[6:0], exp[11], exp[10:7], exp[6:0]);
            end
        end
        tests_run++;
        if (first_ack_cyc != 46 || ack_count != 1) begin
            tests_failed++;
            $display("FAIL held_req_rearm got cyc=%0d count=%0d need cyc=46 count=1", first_ack_cyc, ack_count);
        end
    endtask

    task automatic test_mid_show_req();
        logic [11:0] got;
        logic [11:0] exp;
        apply_reset();
        for (int c = 0; c < 16; c++) begin
            drive_cycle(1'b0, (c >= 2 && c <= 6), 4'h7, 4'hC);
            step_observe(got, exp);
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL mid_show cyc=%0d got ack=%b an=%b seg=%h exp ack=%b an=%b seg=%h",
                         t, got[11], got[10:7], got[6:0], exp[11], exp[10:7], exp[6:0]);
            end
        end
        tests_run++;
        if (first_ack_cyc != 6 || ack_count != 1 || (first_ack_cyc - 2) > (BL + PS + 1)) begin
            tests_failed++;
            $display("FAIL mid_show_ack got cyc=%0d count=%0d need cyc=6 count=1", first_ack_cyc, ack_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [11:0] got;
        logic [11:0] exp;
        logic        req;
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            req = (c == 0 || c == 1 || c == 5 || c == 6);
            if (c < 5) drive_cycle(1'b0, req, 4'h3, 4'hA);
            else       drive_cycle(1'b0, req, 4'h5, 4'hB);
            step_observe(got, exp);
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL pre_reset cyc=%0d got ack=%b an=%b seg=%h exp ack=%b an=%b seg=%h",
                         t, got[11], got[10:7], got[6:0], exp[11], exp[10:7], exp[6:0]);
            end
        end
        drive_cycle(1'b1, 1'b1, 4'h9, 4'h9);
        step_observe(got, exp);
        tests_run++;
        if (got !== 12'h000) begin
            tests_failed++;
            $display("FAIL mid_frame_reset got ack=%b an=%b seg=%h need ack=0 an=0000 seg=00", got[11], got[10:7], got[6:0]);
        end
        ack_count     = 0;
        first_ack_cyc = -1;
        for (int c = 0; c < 21; c++) begin
            drive_cycle(1'b0, 1'b0, 4'h9, 4'h9);
            step_observe(got, exp);
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL post_reset cyc=%0d got ack=%b an=%b seg=%h exp ack=%b an=%b seg=%h",
                         t, got[11], got[10:7], got[6:0], exp[11], exp[10:7], exp[6:0]);
            end
        end
        tests_run++;
        if (ack_count != 0) begin
            tests_failed++;
            $display("FAIL post_reset_no_ack got count=%0d need count=0", ack_count);
        end
    endtask

    task automatic test_random();
        logic [11:0] got;
        logic [11:0] exp;
        logic        req;
        logic        r;
        logic [3:0]  n1, n2;
        apply_reset();
        req = 1'b0;
        n1  = 4'h0;
        n2  = 4'h0;
        for (int c = 0; c < 400; c++) begin
            r = ($urandom_range(0, 99) == 0);
            if (req) begin
                req = ($urandom_range(0, 3) != 0);
            end else begin
                req = ($urandom_range(0, 2) == 0);
                n1  = 4'($urandom_range(0, 15));
                n2  = 4'($urandom_range(0, 15));
            end
            drive_cycle(r, req, n1, n2);
            step_observe(got, exp);
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL random cyc=%0d got ack=%b an=%b seg=%h exp ack=%b an=%b seg=%h",
                         t, got[11], got[10:7], got[6:0], exp[11], exp[10:7], exp[6:0]);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        load_req = 1'b0;
        num1     = 4'h0;
        num2     = 4'h0;
        model_reset();
        test_reset();
        test_first_load();
        test_second_load();
        test_held_req();
        test_mid_show_req();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
